// File: rtl/cb_dequantizer.sv
// Cb dequantizer: serial zigzag-ordered quantized coefficients in, scaled by the
// JPEG chrominance table, assembled into an 8x8 matrix and presented in parallel.
module cb_dequantizer (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [10:0] data_in,
    output logic signed [15:0] coef_out [1:8][1:8],
    output logic               output_enable
);

    // Zigzag position -> natural (row*8 + col) index, both zero-based.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Chrominance quantization table in natural row-major order.
    localparam logic [6:0] Q_TAB [64] = '{
        7'd17, 7'd18, 7'd24, 7'd47, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd18, 7'd21, 7'd26, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd24, 7'd26, 7'd56, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd47, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99
    };

    logic [5:0]         idx_reg;
    logic               blk_done_reg;
    logic [5:0]         pos;
    logic signed [18:0] din_ext;
    logic signed [18:0] q_ext;
    logic signed [18:0] product;
    logic signed [15:0] sat_val;
    logic signed [15:0] work_reg [64];

    assign pos     = ZZ[idx_reg];
    assign din_ext = {{8{data_in[10]}}, data_in};
    assign q_ext   = {12'd0, Q_TAB[pos]};
    assign product = din_ext * q_ext;

    always_comb begin
        sat_val = product[15:0];
        if (product > 19'sd32767)
            sat_val = 16'sh7fff;
        else if (product < -19'sd32768)
            sat_val = 16'sh8000;
    end

    // idx wraps naturally; blk_done lives exactly one cycle after the 64th accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg       <= 6'd0;
            blk_done_reg  <= 1'b0;
            output_enable <= 1'b0;
        end else begin
            if (enable)
                idx_reg <= idx_reg + 6'd1;
            blk_done_reg  <= enable && (idx_reg == 6'd63);
            output_enable <= blk_done_reg;
        end
    end

    // The copy samples pre-edge working values, so a new block's first write
    // on the copy edge cannot leak into the presented matrix.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_cell
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    work_reg[gi]                   <= 16'sd0;
                    coef_out[gi / 8 + 1][gi % 8 + 1] <= 16'sd0;
                end else begin
                    if (enable && (pos == 6'(gi)))
                        work_reg[gi] <= sat_val;
                    if (blk_done_reg)
                        coef_out[gi / 8 + 1][gi % 8 + 1] <= work_reg[gi];
                end
            end
        end
    endgenerate

endmodule
